store_trace_buffer: RTL

- Passive store monitor on the processor data-memory write bus (MemWrite, DataAdr, WriteData) that the single-cycle core top drives.
- Timestamps every store with a sequence number and buffers it in a FIFO.
- Drains the FIFO to a bench/debug consumer over a valid/ready port.
- Detects the end-of-program store and reports done/pass, so benches no longer hard-code the pass check.

---
 rtl/store_trace_buffer_if.sv | 27 ++
 rtl/store_trace_buffer.sv | 110 +++++++++++
 2 files changed

// File: rtl/store_trace_buffer_if.sv
// Head-of-FIFO trace port of the store trace buffer.
// The buffer drives valid/payload; the consumer drives ready.
interface store_trace_buffer_if #(
    parameter int SEQ_W = 16
);
    logic             trace_valid;
    logic             trace_ready;
    logic [31:0]      trace_adr;
    logic [31:0]      trace_data;
    logic [SEQ_W-1:0] trace_seq;

    modport master (
        output trace_valid,
        output trace_adr,
        output trace_data,
        output trace_seq,
        input  trace_ready
    );

    modport slave (
        input  trace_valid,
        input  trace_adr,
        input  trace_data,
        input  trace_seq,
        output trace_ready
    );
endinterface

// File: rtl/store_trace_buffer.sv
// Passive data-memory store monitor: timestamps stores into a FIFO,
// drains them over a valid/ready port and flags end-of-program.
module store_trace_buffer #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] DONE_ADR  = 32'd216,
    parameter logic [31:0] PASS_DATA = 32'd4140,
    parameter int          SEQ_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemWrite,
    input  logic [31:0]           DataAdr,
    input  logic [31:0]           WriteData,
    store_trace_buffer_if.master  trace,
    output logic                  overflow,
    output logic                  misaligned,
    output logic                  done,
    output logic                  pass,
    output logic [SEQ_W-1:0]      store_count
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]      adr_mem  [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [SEQ_W-1:0] seq_mem  [DEPTH];

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [SEQ_W-1:0] seq_q;
    logic             overflow_q;
    logic             misaligned_q;
    logic             done_q;
    logic             pass_q;

    logic empty;
    logic full;
    logic observe;
    logic pop;
    logic push;
    logic drop;

    assign empty = (wr_ptr == rd_ptr);
    // Same index with opposite wrap bits means the write side lapped the read side.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign observe = MemWrite && !done_q;
    assign pop     = !empty && trace.trace_ready;
    assign push    = observe && (!full || pop);
    assign drop    = observe && full && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            seq_q        <= '0;
            overflow_q   <= 1'b0;
            misaligned_q <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (observe) begin
                seq_q <= seq_q + 1'b1;
                if (drop) begin
                    overflow_q <= 1'b1;
                end
                if (DataAdr[1:0] != 2'b00) begin
                    misaligned_q <= 1'b1;
                end
                if (DataAdr == DONE_ADR) begin
                    done_q <= 1'b1;
                    pass_q <= (WriteData == PASS_DATA);
                end
            end
        end
    end

    // Storage needs no reset; the empty flag gates every read.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            adr_mem[wr_ptr[AW-1:0]]  <= DataAdr;
            data_mem[wr_ptr[AW-1:0]] <= WriteData;
            seq_mem[wr_ptr[AW-1:0]]  <= seq_q;
        end
    end

    always_comb begin
        trace.trace_valid = !empty;
        trace.trace_adr   = '0;
        trace.trace_data  = '0;
        trace.trace_seq   = '0;
        if (!empty) begin
            trace.trace_adr  = adr_mem[rd_ptr[AW-1:0]];
            trace.trace_data = data_mem[rd_ptr[AW-1:0]];
            trace.trace_seq  = seq_mem[rd_ptr[AW-1:0]];
        end
    end

    assign overflow    = overflow_q;
    assign misaligned  = misaligned_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign store_count = seq_q;
endmodule
